osd_ram_write_scheduler: RTL and testbench
==========================================

Name: osd_ram_write_scheduler

Overview:
Arbiter and sequencer for the single write port of the OSD character RAM (8 pages x 128 bytes, 10-bit address).
- Requester 1: byte writes from the I2C register interface.
- Requester 2: an internal page-fill engine that clears or fills a whole page with one character code.
- I2C writes always win. The fill engine advances only on free cycles.
- Sits between the I2C register interface and the OSD RAM write port.

Parameters:
PAGE_BITS, 7, log2 bytes per page (128).
PAGE_SEL_BITS, 3, page select width; RAM address width = PAGE_SEL_BITS+PAGE_BITS = 10.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i2c_wren  in  1  single-cycle I2C write strobe
i2c_wraddress  in  10  I2C write address {page, offset}
i2c_data  in  8  I2C write data
fill_req  in  1  single-cycle request to fill a page
fill_page  in  3  page to fill, sampled with fill_req
fill_char  in  8  fill byte, sampled with fill_req
fill_busy  out  1  high while a fill is active or pending
fill_done  out  1  one-cycle pulse after the last byte of a fill is written
fill_dropped  out  1  sticky; set when fill_req arrives while a fill is pending; cleared only by reset
ram_wren  out  1  RAM write enable
ram_wraddress  out  10  RAM write address
ram_data  out  8  RAM write data

Behaviour:
Reset values:
- All outputs 0.
- State IDLE, cursor 0, pending slot empty.

Output timing:
- All RAM outputs are registered.
- A write granted in cycle N appears on ram_* in cycle N+1 with ram_wren=1 for exactly one cycle.

Arbitration, evaluated each cycle:
- i2c_wren=1: grant I2C. Output {i2c_wraddress, i2c_data}. The fill cursor does not advance.
- Otherwise, in state FILL: grant fill. Output {cur_page, cursor, cur_char}, then cursor <= cursor+1.
- Otherwise: ram_wren=0.

State machine (IDLE, FILL):
- IDLE -> FILL on fill_req. Latch cur_page and cur_char, cursor <= 0.
- In FILL, a fill write with cursor = 2^PAGE_BITS-1:
  - fill_done pulses (1 cycle, aligned with that last byte's ram_wren).
  - Cursor wraps to 0.
  - If the pending slot is full: load it and stay in FILL with no idle cycle; fill_done still pulses.
  - Else: -> IDLE.
- A fill never completes early. It needs exactly 128 granted cycles, so 128 + (number of I2C writes during the fill) cycles in total.

Request handling:
- fill_req in FILL with the pending slot empty: store page and char in the pending slot.
- fill_req with the pending slot full: drop the request, set fill_dropped.
- fill_req in the same cycle as the final fill write: it goes to the pending slot, which is guaranteed empty after the load.
- fill_busy = (state==FILL) | pending_valid, registered.

Overlapping writes:
- An I2C write to the page being filled is performed unchanged.
- If its offset >= cursor, the fill later overwrites it. This is the defined behaviour; software waits for fill_done.
- i2c_wren and fill_req in the same cycle: the I2C write is granted and the fill request is accepted; both happen.

Reset mid-fill: aborts immediately. No fill_done, no further writes, pending slot cleared.

Optional Feature:
OSD_FILL_ALL_EN
- With the macro: extra input fill_all (1 bit, sampled with fill_req).
  - When 1, the fill covers all pages 0..7 in order: 1024 granted cycles, a single fill_done after address 0x3FF.
  - The cursor is treated as {page, offset}, wrapping from 0x3FF to 0.
  - fill_page is ignored for that request.
- Without the macro: no fill_all port; every fill covers one page.

Decomposition:
- Shared package osd_pkg:
  - Constants OSD_PAGE_BITS=7, OSD_PAGE_SEL_BITS=3, OSD_ADDR_BITS=10.
  - typedef OsdFillReq struct {page[2:0], char[7:0], all} for the pending slot and active request registers.
  - typedef enum OsdFillState {IDLE, FILL}.
- No sub-module is needed. The single-entry pending slot is small enough to stay inline.

Test Plan:
1. Reset, then fill_req page=2 char=0x20, no I2C traffic -> ram_wren high for 128 consecutive cycles, addresses 0x100..0x17F, data 0x20; fill_done on the 0x17F write; fill_busy low next cycle.
2. Page-3 fill; after 10 fill writes, assert i2c_wren addr=0x005 data=0x41 on 3 consecutive cycles -> three I2C writes to 0x005; fill pauses at 0x18A and resumes at 0x18A; total duration 131 cycles.
3. Fill page 0, then fill_req page 1 mid-fill, then fill_req page 4 -> page 0 completes, page 1 starts the next cycle (two fill_done pulses total); page-4 request dropped, fill_dropped=1.
4. Assert reset at cursor 0x40 of a page-5 fill with a pending request -> next cycle: ram_wren=0, fill_busy=0, no fill_done, fill_dropped=0.
5. i2c_wren addr=0x3FF data=0x7E in the same cycle as fill_req page=7 char=0x00 -> 0x3FF written with 0x7E first, then fill 0x380..0x3FF with 0x00 (0x3FF finally 0x00).
6. (OSD_FILL_ALL_EN) fill_req fill_all=1 char=0xFF -> 1024 writes 0x000..0x3FF, single fill_done at 0x3FF.

Source files
------------

// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD character RAM write scheduler.
// The optional whole-RAM fill is enabled by defining OSD_FILL_ALL_EN.
package osd_pkg;

    localparam int OSD_PAGE_BITS     = 7;
    localparam int OSD_PAGE_SEL_BITS = 3;
    localparam int OSD_ADDR_BITS     = OSD_PAGE_SEL_BITS + OSD_PAGE_BITS;

    // One fill request: target page, fill byte, and whole-RAM flag.
    typedef struct packed {
        logic [OSD_PAGE_SEL_BITS-1:0] page;
        logic [7:0]                   chr;
        logic                         all;
    } OsdFillReq;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } OsdFillState;

endpackage

// File: rtl/osd_ram_write_scheduler.sv
// Write-port arbiter for the OSD character RAM: I2C byte writes always win, the
// page-fill engine uses the free cycles. OSD_FILL_ALL_EN adds the fill_all input.
module osd_ram_write_scheduler
    import osd_pkg::*;
#(
    parameter int PAGE_BITS     = OSD_PAGE_BITS,
    parameter int PAGE_SEL_BITS = OSD_PAGE_SEL_BITS,
    localparam int ADDR_BITS    = PAGE_SEL_BITS + PAGE_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i2c_wren,
    input  logic [ADDR_BITS-1:0]     i2c_wraddress,
    input  logic [7:0]               i2c_data,
    input  logic                     fill_req,
    input  logic [PAGE_SEL_BITS-1:0] fill_page,
    input  logic [7:0]               fill_char,
`ifdef OSD_FILL_ALL_EN
    input  logic                     fill_all,
`endif
    output logic                     fill_busy,
    output logic                     fill_done,
    output logic                     fill_dropped,
    output logic                     ram_wren,
    output logic [ADDR_BITS-1:0]     ram_wraddress,
    output logic [7:0]               ram_data,
    output OsdFillState              dbg_state
);

    OsdFillState            state_q, state_d;
    OsdFillReq              act_q, act_d;
    OsdFillReq              pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [ADDR_BITS-1:0]   cursor_q, cursor_d;
    logic                   ram_wren_q, ram_wren_d;
    logic [ADDR_BITS-1:0]   ram_wraddress_q, ram_wraddress_d;
    logic [7:0]             ram_data_q, ram_data_d;
    logic                   fill_done_q, fill_done_d;
    logic                   fill_busy_q, fill_busy_d;
    logic                   fill_dropped_q, fill_dropped_d;

    logic                   req_all;
    OsdFillReq              new_req;
    logic [ADDR_BITS-1:0]   fill_addr;
    logic                   last_byte;
    logic                   grant_fill;
    logic                   finishing;

`ifdef OSD_FILL_ALL_EN
    assign req_all = fill_all;
`else
    assign req_all = 1'b0;
`endif

    assign new_req = '{page: fill_page, chr: fill_char, all: req_all};

    // A whole-RAM fill walks the full cursor; a page fill uses only the offset bits.
    assign fill_addr  = act_q.all ? cursor_q : {act_q.page, cursor_q[PAGE_BITS-1:0]};
    assign last_byte  = act_q.all ? (&cursor_q) : (&cursor_q[PAGE_BITS-1:0]);
    assign grant_fill = !i2c_wren && (state_q == FILL);
    assign finishing  = grant_fill && last_byte;

    always_comb begin
        state_d         = state_q;
        act_d           = act_q;
        pend_d          = pend_q;
        pend_valid_d    = pend_valid_q;
        cursor_d        = cursor_q;
        ram_wren_d      = 1'b0;
        ram_wraddress_d = '0;
        ram_data_d      = '0;
        fill_done_d     = 1'b0;
        fill_dropped_d  = fill_dropped_q;

        if (i2c_wren) begin
            ram_wren_d      = 1'b1;
            ram_wraddress_d = i2c_wraddress;
            ram_data_d      = i2c_data;
        end else if (grant_fill) begin
            ram_wren_d      = 1'b1;
            ram_wraddress_d = fill_addr;
            ram_data_d      = act_q.chr;
            if (last_byte) begin
                fill_done_d = 1'b1;
                cursor_d    = '0;
                if (pend_valid_q) begin
                    act_d        = pend_q;
                    pend_valid_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                cursor_d = cursor_q + 1'b1;
            end
        end

        // A request landing on the final byte with nothing queued starts straight away.
        if (fill_req) begin
            if (state_q == IDLE || (finishing && !pend_valid_q)) begin
                act_d    = new_req;
                cursor_d = '0;
                state_d  = FILL;
            end else if (!pend_valid_q || finishing) begin
                pend_d       = new_req;
                pend_valid_d = 1'b1;
            end else begin
                fill_dropped_d = 1'b1;
            end
        end

        fill_busy_d = (state_d == FILL) | pend_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            act_q           <= '0;
            pend_q          <= '0;
            pend_valid_q    <= 1'b0;
            cursor_q        <= '0;
            ram_wren_q      <= 1'b0;
            ram_wraddress_q <= '0;
            ram_data_q      <= '0;
            fill_done_q     <= 1'b0;
            fill_busy_q     <= 1'b0;
            fill_dropped_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            act_q           <= act_d;
            pend_q          <= pend_d;
            pend_valid_q    <= pend_valid_d;
            cursor_q        <= cursor_d;
            ram_wren_q      <= ram_wren_d;
            ram_wraddress_q <= ram_wraddress_d;
            ram_data_q      <= ram_data_d;
            fill_done_q     <= fill_done_d;
            fill_busy_q     <= fill_busy_d;
            fill_dropped_q  <= fill_dropped_d;
        end
    end

    assign ram_wren      = ram_wren_q;
    assign ram_wraddress = ram_wraddress_q;
    assign ram_data      = ram_data_q;
    assign fill_done     = fill_done_q;
    assign fill_busy     = fill_busy_q;
    assign fill_dropped  = fill_dropped_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_osd_ram_write_scheduler.sv
// Self-checking bench for osd_ram_write_scheduler: directed scenarios plus random
// traffic, all checked against a queue-based model of the RAM write stream.
module tb_osd_ram_write_scheduler;
    import osd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i2c_wren;
    logic [9:0]  i2c_wraddress;
    logic [7:0]  i2c_data;
    logic        fill_req;
    logic [2:0]  fill_page;
    logic [7:0]  fill_char;
`ifdef OSD_FILL_ALL_EN
    logic        fill_all;
`endif
    logic        fill_busy;
    logic        fill_done;
    logic        fill_dropped;
    logic        ram_wren;
    logic [9:0]  ram_wraddress;
    logic [7:0]  ram_data;
    OsdFillState dbg_state;

    int checks   = 0;
    int failures = 0;

    // Per-cycle observation: {wren, done, busy, dropped, addr[9:0], data[7:0]}
    logic [21:0] exp_q[$];
    logic [21:0] act_q[$];

    // Model: remaining fill bytes {last, addr, data} plus a one-entry pending request.
    logic [18:0] fq[$];
    logic        m_pv;
    logic [2:0]  m_pp;
    logic [7:0]  m_pc;
    logic        m_pa;
    logic        m_dropped;

    always #5 clk = ~clk;

    osd_ram_write_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .i2c_wren      (i2c_wren),
        .i2c_wraddress (i2c_wraddress),
        .i2c_data      (i2c_data),
        .fill_req      (fill_req),
        .fill_page     (fill_page),
        .fill_char     (fill_char),
`ifdef OSD_FILL_ALL_EN
        .fill_all      (fill_all),
`endif
        .fill_busy     (fill_busy),
        .fill_done     (fill_done),
        .fill_dropped  (fill_dropped),
        .ram_wren      (ram_wren),
        .ram_wraddress (ram_wraddress),
        .ram_data      (ram_data),
        .dbg_state     (dbg_state)
    );

    task automatic model_push_fill(input logic [2:0] pg, input logic [7:0] ch, input logic al);
        int n;
        logic [9:0] a;
        n = al ? 1024 : 128;
        for (int i = 0; i < n; i++) begin
            a = al ? 10'(i) : {pg, 7'(i)};
            fq.push_back({(i == n - 1), a, ch});
        end
    endtask

    task automatic model_clear();
        fq.delete();
        m_pv      = 1'b0;
        m_pp      = '0;
        m_pc      = '0;
        m_pa      = 1'b0;
        m_dropped = 1'b0;
    endtask

    // Drive one cycle, advance the model, and record expected and observed outputs.
    task automatic step(input logic we, input logic [9:0] wa, input logic [7:0] wd,
                        input logic fr, input logic [2:0] fp, input logic [7:0] fc, input logic fa);
        logic       ew, ed, eb;
        logic [9:0] ea;
        logic [7:0] edat;
        logic [18:0] w;
        i2c_wren      = we;
        i2c_wraddress = wa;
        i2c_data      = wd;
        fill_req      = fr;
        fill_page     = fp;
        fill_char     = fc;
`ifdef OSD_FILL_ALL_EN
        fill_all      = fa;
`endif
        ew = 1'b0; ed = 1'b0; ea = '0; edat = '0;
        if (we) begin
            ew = 1'b1; ea = wa; edat = wd;
        end else if (fq.size() > 0) begin
            w = fq.pop_front();
            ew = 1'b1;
            {ed, ea, edat} = w;
            if (fq.size() == 0 && m_pv) begin
                model_push_fill(m_pp, m_pc, m_pa);
                m_pv = 1'b0;
            end
        end
        if (fr) begin
            if (fq.size() == 0 && !m_pv) begin
                model_push_fill(fp, fc, fa);
            end else if (!m_pv) begin
                m_pv = 1'b1; m_pp = fp; m_pc = fc; m_pa = fa;
            end else begin
                m_dropped = 1'b1;
            end
        end
        eb = (fq.size() > 0) || m_pv;
        exp_q.push_back({ew, ed, eb, m_dropped, ea, edat});
        @(posedge clk);
        #1;
        act_q.push_back({ram_wren, fill_done, fill_busy, fill_dropped, ram_wraddress, ram_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i2c_wren = 1'b0; i2c_wraddress = '0; i2c_data = '0;
        fill_req = 1'b0; fill_page = '0; fill_char = '0;
`ifdef OSD_FILL_ALL_EN
        fill_all = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (ram_wren !== 1'b0)      begin failures++; $display("FAIL reset_wren got %b expected 0", ram_wren); end
        if (ram_wraddress !== 10'h0) begin failures++; $display("FAIL reset_addr got %h expected 000", ram_wraddress); end
        if (ram_data !== 8'h0)      begin failures++; $display("FAIL reset_data got %h expected 00", ram_data); end
        if (fill_busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got %b expected 0", fill_busy); end
        if (fill_done !== 1'b0)     begin failures++; $display("FAIL reset_done got %b expected 0", fill_done); end
        if (fill_dropped !== 1'b0)  begin failures++; $display("FAIL reset_dropped got %b expected 0", fill_dropped); end
        if (dbg_state !== IDLE)     begin failures++; $display("FAIL reset_state got %0d expected IDLE", dbg_state); end
    endtask

    task automatic test_single_fill();
        int nw, nd, k, nbad;
        logic [21:0] e, a;
        do_reset();
        step(1'b0, '0, '0, 1'b1, 3'd2, 8'h20, 1'b0);
        idle(131);
        nw = 0; nd = 0;
        foreach (act_q[i]) begin
            if (act_q[i][21]) nw++;
            if (act_q[i][20]) nd++;
        end
        checks += 3;
        if (nw != 128) begin failures++; $display("FAIL single_fill_count got %0d expected 128", nw); end
        if (nd != 1)   begin failures++; $display("FAIL single_fill_done got %0d expected 1", nd); end
        if (act_q[1][17:0] !== {10'h100, 8'h20}) begin
            failures++; $display("FAIL single_fill_first got %h expected 10020", act_q[1][17:0]);
        end
        k = 0; nbad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin
                failures++;
                if (nbad < 4) $display("FAIL single_fill step %0d got %h expected %h", k, a, e);
                nbad++;
            end
            k++;
        end
    endtask

    task automatic test_i2c_pause();
        int first, last, k, nbad;
        logic [21:0] e, a;
        do_reset();
        step(1'b0, '0, '0, 1'b1, 3'd3, 8'h55, 1'b0);
        idle(10);
        repeat (3) step(1'b1, 10'h005, 8'h41, 1'b0, '0, '0, 1'b0);
        idle(125);
        first = -1; last = -1;
        foreach (act_q[i]) begin
            if (first < 0 && act_q[i][21] && act_q[i][17:8] == 10'h180) first = i;
            if (act_q[i][20]) last = i;
        end
        checks += 2;
        if (last - first + 1 != 131) begin
            failures++; $display("FAIL i2c_pause_duration got %0d expected 131", last - first + 1);
        end
        if (act_q[14][17:0] !== {10'h18A, 8'h55}) begin
            failures++; $display("FAIL i2c_pause_resume got %h expected 18a55", act_q[14][17:0]);
        end
        k = 0; nbad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin
                failures++;
                if (nbad < 4) $display("FAIL i2c_pause step %0d got %h expected %h", k, a, e);
                nbad++;
            end
            k++;
        end
    endtask

    task automatic test_pending_drop();
        int nd, d1, k, nbad;
        logic [21:0] e, a;
        do_reset();
        step(1'b0, '0, '0, 1'b1, 3'd0, 8'h11, 1'b0);
        idle(20);
        step(1'b0, '0, '0, 1'b1, 3'd1, 8'h22, 1'b0);
        idle(5);
        step(1'b0, '0, '0, 1'b1, 3'd4, 8'h44, 1'b0);
        idle(240);
        nd = 0; d1 = -1;
        foreach (act_q[i]) if (act_q[i][20]) begin
            nd++;
            if (d1 < 0) d1 = i;
        end
        checks += 3;
        if (nd != 2) begin failures++; $display("FAIL pending_done_count got %0d expected 2", nd); end
        if (d1 < 0 || act_q[d1 + 1][21:8] !== {1'b1, 3'b???, 10'h080} && act_q[d1 + 1][17:8] !== 10'h080) begin
            failures++; $display("FAIL pending_back_to_back got index %0d", d1);
        end
        if (fill_dropped !== 1'b1) begin failures++; $display("FAIL pending_dropped got %b expected 1", fill_dropped); end
        k = 0; nbad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin
                failures++;
                if (nbad < 4) $display("FAIL pending_drop step %0d got %h expected %h", k, a, e);
                nbad++;
            end
            k++;
        end
    endtask

    task automatic test_reset_mid_fill();
        int k, nbad;
        logic [21:0] e, a;
        do_reset();
        step(1'b0, '0, '0, 1'b1, 3'd5, 8'h66, 1'b0);
        idle(20);
        step(1'b0, '0, '0, 1'b1, 3'd6, 8'h77, 1'b0);
        step(1'b0, '0, '0, 1'b1, 3'd1, 8'h88, 1'b0);
        idle(42);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks += 4;
        if (ram_wren !== 1'b0)     begin failures++; $display("FAIL midreset_wren got %b expected 0", ram_wren); end
        if (fill_busy !== 1'b0)    begin failures++; $display("FAIL midreset_busy got %b expected 0", fill_busy); end
        if (fill_done !== 1'b0)    begin failures++; $display("FAIL midreset_done got %b expected 0", fill_done); end
        if (fill_dropped !== 1'b0) begin failures++; $display("FAIL midreset_dropped got %b expected 0", fill_dropped); end
        model_clear();
        idle(140);
        k = 0; nbad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin
                failures++;
                if (nbad < 4) $display("FAIL reset_mid step %0d got %h expected %h", k, a, e);
                nbad++;
            end
            k++;
        end
    endtask

    task automatic test_same_cycle();
        int k, nbad;
        logic [21:0] e, a;
        do_reset();
        step(1'b1, 10'h3FF, 8'h7E, 1'b1, 3'd7, 8'h00, 1'b0);
        idle(130);
        checks += 2;
        if (act_q[0][21:18] !== 4'b1010 || act_q[0][17:0] !== {10'h3FF, 8'h7E}) begin
            failures++; $display("FAIL same_cycle_i2c got %h expected 2bff7e", act_q[0]);
        end
        if (act_q[128][17:0] !== {10'h3FF, 8'h00} || act_q[128][20] !== 1'b1) begin
            failures++; $display("FAIL same_cycle_last got %h expected done at 3ff00", act_q[128]);
        end
        k = 0; nbad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin
                failures++;
                if (nbad < 4) $display("FAIL same_cycle step %0d got %h expected %h", k, a, e);
                nbad++;
            end
            k++;
        end
    endtask

    task automatic test_random();
        int k, nbad;
        logic [21:0] e, a;
        logic we, fr, fa;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            we = ($urandom_range(0, 3) == 0);
            fr = ($urandom_range(0, 39) == 0);
`ifdef OSD_FILL_ALL_EN
            fa = ($urandom_range(0, 15) == 0);
`else
            fa = 1'b0;
`endif
            step(we, 10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)),
                 fr, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), fa);
        end
        k = 0; nbad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin
                failures++;
                if (nbad < 4) $display("FAIL random step %0d got %h expected %h", k, a, e);
                nbad++;
            end
            k++;
        end
    endtask

`ifdef OSD_FILL_ALL_EN
    task automatic test_fill_all();
        int nd, nw, k, nbad;
        logic [21:0] e, a;
        do_reset();
        step(1'b0, '0, '0, 1'b1, 3'd3, 8'hFF, 1'b1);
        idle(1030);
        nd = 0; nw = 0;
        foreach (act_q[i]) begin
            if (act_q[i][21]) nw++;
            if (act_q[i][20]) nd++;
        end
        checks += 2;
        if (nw != 1024) begin failures++; $display("FAIL fill_all_count got %0d expected 1024", nw); end
        if (nd != 1)    begin failures++; $display("FAIL fill_all_done got %0d expected 1", nd); end
        k = 0; nbad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin
                failures++;
                if (nbad < 4) $display("FAIL fill_all step %0d got %h expected %h", k, a, e);
                nbad++;
            end
            k++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        model_clear();
        test_reset();
        test_single_fill();
        test_i2c_pause();
        test_pending_drop();
        test_reset_mid_fill();
        test_same_cycle();
        test_random();
`ifdef OSD_FILL_ALL_EN
        test_fill_all();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
